// File: rtl/cajero_pkg.sv
// Shared definitions for the cajero balance arbiter: FSM state codes and
// transaction-type constants.
package cajero_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic TRANS_DEPOSITO = 1'b0;
  localparam logic TRANS_RETIRO   = 1'b1;

endpackage

// File: rtl/arbitro_rr_prioridad.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// wrapping around to index 0.
module arbitro_rr_prioridad
  import cajero_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [IDX_W-1:0]   index,
  output logic               any
);

  localparam int unsigned N = NUM_REQ;

  int unsigned    w_pos;
  logic [IDX_W-1:0] w_j;

  always_comb begin
    win   = '0;
    index = '0;
    any   = 1'b0;
    w_pos = 0;
    w_j   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_pos = 32'(rr_ptr) + i;
      if (w_pos >= N) w_pos = w_pos - N;
      w_j = IDX_W'(w_pos);
      if (!any && req[w_j]) begin
        any      = 1'b1;
        win[w_j] = 1'b1;
        index    = w_j;
      end
    end
  end

endmodule

// File: rtl/arbitro_saldo_cajeros.sv
// Round-robin arbiter that serialises deposit/withdrawal requests from several
// cajero controllers onto one shared balance register.
module arbitro_saldo_cajeros
  import cajero_pkg::*;
#(
  parameter int                 NUM_REQ      = 2,
  parameter int                 MONTO_W      = 32,
  parameter logic [MONTO_W-1:0] BALANCE_INIT = MONTO_W'(10000)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         tipo_trans,
  input  logic [NUM_REQ*MONTO_W-1:0] monto,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic                       balance_actualizado,
  output logic                       entregar_dinero,
  output logic                       fondos_insuficientes,
  output logic                       desborde,
  output logic [MONTO_W-1:0]         saldo,
  output logic                       ocupado
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [1:0]         r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_idx;
  logic [NUM_REQ-1:0] r_onehot;
  logic               r_tipo;
  logic [MONTO_W-1:0] r_monto;
  logic [MONTO_W-1:0] r_saldo;
  logic               r_bal;
  logic               r_ent;
  logic               r_fondos;
  logic               r_desb;

  logic [NUM_REQ-1:0] w_win;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic [MONTO_W:0]   w_suma;
  logic [MONTO_W-1:0] w_resta;
  logic               w_insuf;

  arbitro_rr_prioridad #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req    (req),
    .rr_ptr (r_ptr),
    .win    (w_win),
    .index  (w_idx),
    .any    (w_any)
  );

  // The extra sum bit is the overflow carry; the compare is the borrow.
  assign w_suma  = {1'b0, r_saldo} + {1'b0, r_monto};
  assign w_resta = r_saldo - r_monto;
  assign w_insuf = (r_monto > r_saldo);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_idx    <= '0;
      r_onehot <= '0;
      r_tipo   <= 1'b0;
      r_monto  <= '0;
      r_saldo  <= BALANCE_INIT;
      r_bal    <= 1'b0;
      r_ent    <= 1'b0;
      r_fondos <= 1'b0;
      r_desb   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_bal    <= 1'b0;
          r_ent    <= 1'b0;
          r_fondos <= 1'b0;
          r_desb   <= 1'b0;
          if (w_any) begin
            r_idx    <= w_idx;
            r_onehot <= w_win;
            r_tipo   <= tipo_trans[w_idx];
            r_monto  <= monto[w_idx*MONTO_W +: MONTO_W];
            r_state  <= EXEC;
          end
        end
        EXEC: begin
          if (r_tipo == TRANS_DEPOSITO) begin
            if (w_suma[MONTO_W]) begin
              r_desb <= 1'b1;
            end else begin
              r_saldo <= w_suma[MONTO_W-1:0];
              r_bal   <= 1'b1;
            end
          end else begin
            if (w_insuf) begin
              r_fondos <= 1'b1;
            end else begin
              r_saldo <= w_resta;
              r_bal   <= 1'b1;
              r_ent   <= 1'b1;
            end
          end
          r_state <= RESP;
        end
        RESP: begin
          r_bal    <= 1'b0;
          r_ent    <= 1'b0;
          r_fondos <= 1'b0;
          r_desb   <= 1'b0;
          r_ptr    <= (r_idx == IDX_W'(NUM_REQ-1)) ? '0 : r_idx + 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt                  = (r_state == EXEC) ? r_onehot : '0;
  assign done                 = (r_state == RESP) ? r_onehot : '0;
  assign ocupado              = (r_state != IDLE);
  assign saldo                = r_saldo;
  assign balance_actualizado  = r_bal;
  assign entregar_dinero      = r_ent;
  assign fondos_insuficientes = r_fondos;
  assign desborde             = r_desb;

endmodule

// File: tb/tb_arbitro_saldo_cajeros.sv
// Self-checking bench for arbitro_saldo_cajeros: directed scenarios followed by
// randomized traffic, checked against an arithmetic balance/round-robin model.
module tb_arbitro_saldo_cajeros;

  localparam int     NUM_REQ = 2;
  localparam int     MONTO_W = 32;
  localparam longint INIT    = 10000;
  localparam longint MAXV    = 64'h0000_0000_FFFF_FFFF;

  logic                       clk        = 1'b0;
  logic                       reset      = 1'b1;
  logic [NUM_REQ-1:0]         req        = '0;
  logic [NUM_REQ-1:0]         tipo_trans = '0;
  logic [NUM_REQ*MONTO_W-1:0] monto      = '0;
  logic [NUM_REQ-1:0]         gnt;
  logic [NUM_REQ-1:0]         done;
  logic                       balance_actualizado;
  logic                       entregar_dinero;
  logic                       fondos_insuficientes;
  logic                       desborde;
  logic [MONTO_W-1:0]         saldo;
  logic                       ocupado;

  int     n_chk  = 0;
  int     n_fail = 0;
  longint m_saldo = INIT;
  int     m_ptr   = 0;

  arbitro_saldo_cajeros #(
    .NUM_REQ      (NUM_REQ),
    .MONTO_W      (MONTO_W),
    .BALANCE_INIT (32'd10000)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .req                  (req),
    .tipo_trans           (tipo_trans),
    .monto                (monto),
    .gnt                  (gnt),
    .done                 (done),
    .balance_actualizado  (balance_actualizado),
    .entregar_dinero      (entregar_dinero),
    .fondos_insuficientes (fondos_insuficientes),
    .desborde             (desborde),
    .saldo                (saldo),
    .ocupado              (ocupado)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-cycle invariants on one-hotness and on the result flags.
  always @(negedge clk) begin
    if (reset) begin
      chk("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
      chk("done_onehot0", 64'($onehot0(done)), 64'd1);
      if (|done)
        chk("one_result_flag", 64'($countones({desborde, fondos_insuficientes, balance_actualizado})), 64'd1);
      else
        chk("flags_idle", {60'd0, balance_actualizado, entregar_dinero, fondos_insuficientes, desborde}, 64'd0);
    end
  end

  function automatic int pick(input logic [NUM_REQ-1:0] r);
    for (int i = 0; i < NUM_REQ; i++) begin
      int j;
      j = (m_ptr + i) % NUM_REQ;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic set_op(input int k, input logic t, input logic [MONTO_W-1:0] m);
    tipo_trans[k] = t;
    monto[k*MONTO_W +: MONTO_W] = m;
    req[k] = 1'b1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    tick;
    tick;
    reset = 1'b1;
    m_saldo = INIT;
    m_ptr = 0;
  endtask

  // Called with state IDLE and requests already presented; returns the winner at RESP.
  task automatic serve(input string tag, output int w);
    logic [63:0] mo;
    logic        t, ea, ee, ef, ed;
    w  = pick(req);
    t  = tipo_trans[w];
    mo = 64'(monto[w*MONTO_W +: MONTO_W]);
    tick;
    chk({tag, "_gnt"}, 64'(gnt), 64'(1) << w);
    chk({tag, "_ocupado_exec"}, 64'(ocupado), 64'd1);
    ea = 1'b0; ee = 1'b0; ef = 1'b0; ed = 1'b0;
    if (t == 1'b0) begin
      if (m_saldo + mo > MAXV) ed = 1'b1;
      else begin m_saldo = m_saldo + mo; ea = 1'b1; end
    end else begin
      if (mo > m_saldo) ef = 1'b1;
      else begin m_saldo = m_saldo - mo; ea = 1'b1; ee = 1'b1; end
    end
    tick;
    chk({tag, "_done"}, 64'(done), 64'(1) << w);
    chk({tag, "_gnt_resp"}, 64'(gnt), 64'd0);
    chk({tag, "_flags"}, {60'd0, balance_actualizado, entregar_dinero, fondos_insuficientes, desborde},
        {60'd0, ea, ee, ef, ed});
    chk({tag, "_saldo"}, 64'(saldo), m_saldo);
    m_ptr = (w + 1) % NUM_REQ;
  endtask

  task automatic back_idle(input string tag);
    tick;
    chk({tag, "_ocupado_idle"}, 64'(ocupado), 64'd0);
    chk({tag, "_done_idle"}, 64'(done), 64'd0);
  endtask

  initial begin
    int w;
    #1 reset = 1'b0;
    tick;
    tick;
    chk("rst_saldo", 64'(saldo), INIT);
    chk("rst_gnt_done", {gnt, done}, 64'd0);
    chk("rst_flags", {balance_actualizado, entregar_dinero, fondos_insuficientes, desborde}, 64'd0);
    chk("rst_ocupado", 64'(ocupado), 64'd0);
    reset = 1'b1;
    tick;

    // 1: single deposit
    set_op(0, 1'b0, 32'd100);
    serve("t1", w);
    chk("t1_saldo_abs", 64'(saldo), 64'd10100);
    chk("t1_bal_act", 64'(balance_actualizado), 64'd1);
    req[w] = 1'b0;
    back_idle("t1");

    // 2: withdraw everything, then withdraw with nothing left
    set_op(1, 1'b1, 32'd10100);
    serve("t2a", w);
    chk("t2a_entregar", 64'(entregar_dinero), 64'd1);
    chk("t2a_saldo_zero", 64'(saldo), 64'd0);
    req[w] = 1'b0;
    back_idle("t2a");
    set_op(1, 1'b1, 32'd1);
    serve("t2b", w);
    chk("t2b_fondos", 64'(fondos_insuficientes), 64'd1);
    req[w] = 1'b0;
    back_idle("t2b");

    // 3: simultaneous deposits from rr_ptr = 0
    do_reset;
    set_op(0, 1'b0, 32'd5);
    set_op(1, 1'b0, 32'd5);
    serve("t3a", w);
    chk("t3a_winner", 64'(w), 64'd0);
    req[w] = 1'b0;
    back_idle("t3a");
    serve("t3b", w);
    chk("t3b_winner", 64'(w), 64'd1);
    chk("t3b_saldo_abs", 64'(saldo), INIT + 10);
    req[w] = 1'b0;
    back_idle("t3b");

    // 4: overflow boundary and zero/equal amounts
    set_op(0, 1'b0, 32'hFFFF_FFF0 - m_saldo[31:0]);
    serve("t4a", w); req[w] = 1'b0; back_idle("t4a");
    chk("t4a_saldo_abs", 64'(saldo), 64'hFFFF_FFF0);
    set_op(1, 1'b0, 32'h10);
    serve("t4b", w); req[w] = 1'b0; back_idle("t4b");
    set_op(0, 1'b0, 32'hF);
    serve("t4c", w); req[w] = 1'b0; back_idle("t4c");
    chk("t4c_saldo_max", 64'(saldo), 64'hFFFF_FFFF);
    set_op(1, 1'b0, 32'd0);
    serve("t4d", w); req[w] = 1'b0; back_idle("t4d");
    set_op(0, 1'b1, 32'd0);
    serve("t4e", w); req[w] = 1'b0; back_idle("t4e");
    set_op(1, 1'b1, 32'hFFFF_FFFF);
    serve("t4f", w); req[w] = 1'b0; back_idle("t4f");

    // 5: reset during EXEC of a withdrawal
    set_op(1, 1'b1, 32'd50);
    tick;
    chk("t5_gnt_exec", 64'(gnt), 64'd2);
    #1 reset = 1'b0;
    #1;
    chk("t5_gnt_done", {gnt, done}, 64'd0);
    chk("t5_flags", {balance_actualizado, entregar_dinero, fondos_insuficientes, desborde}, 64'd0);
    chk("t5_saldo", 64'(saldo), INIT);
    chk("t5_ocupado", 64'(ocupado), 64'd0);
    req = '0;
    tick;
    tick;
    reset = 1'b1;
    m_saldo = INIT;
    m_ptr = 0;
    tick;
    chk("t5_no_done", 64'(done), 64'd0);

    // 6: both requests held continuously
    set_op(0, 1'b0, 32'd1);
    set_op(1, 1'b1, 32'd3);
    for (int i = 0; i < 6; i++) begin
      serve("t6", w);
      chk("t6_alternate", 64'(w), 64'(i % 2));
      back_idle("t6");
    end
    req = '0;
    tick;

    // Randomized traffic; each requester holds until its done
    for (int it = 0; it < 80; it++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!req[k] && ($urandom_range(0, 2) != 0)) begin
          logic [MONTO_W-1:0] m;
          int sel;
          sel = $urandom_range(0, 3);
          case (sel)
            0:       m = $urandom;
            1:       m = MONTO_W'($urandom_range(0, 1000));
            2:       m = m_saldo[31:0];
            default: m = (MAXV - m_saldo) >= 0 ? 32'(MAXV - m_saldo) : 32'd0;
          endcase
          set_op(k, 1'($urandom_range(0, 1)), m);
        end
      end
      if (|req) begin
        serve("rnd", w);
        req[w] = 1'b0;
        back_idle("rnd");
      end else begin
        tick;
        chk("rnd_idle", 64'(ocupado), 64'd0);
      end
    end
    req = '0;
    tick;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
